// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the waveform sequencer.
// Imported by the sequencer top and its tick divider.
package wave_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  localparam int SHAPE_RHOMB  = 0;
  localparam int SHAPE_TRI    = 1;
  localparam int SHAPE_SAW    = 2;
  localparam int SHAPE_SQR    = 3;

  localparam int PHASE_W      = 8;
  localparam int PERIOD_TICKS = 512;

endpackage

// File: rtl/wave_sequencer_tick_divider.sv
// Sample-rate divider: strobes once every div_val_i+1 enabled clocks.
// The strobe is combinational; the sequencer registers it.
module tick_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_val_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Waveform sequencer: walks enabled shapes, playing reps periods
// of 512 ticks each, and drives cout/res/wave_sel to the generators.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter  int DIV_W   = 8,
  parameter  int NSHAPES = 4,
  parameter  int REP_W   = 4,
  localparam int SEL_W   = (NSHAPES > 1) ? $clog2(NSHAPES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   freq_div,
  input  logic [NSHAPES-1:0] shape_mask,
  input  logic [REP_W-1:0]   reps,
  output logic [PHASE_W-1:0] cout,
  output logic               res,
  output logic [SEL_W-1:0]   wave_sel,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  state_e state_q, state_d;

  logic [DIV_W-1:0]   fdiv_q, fdiv_d;
  logic [NSHAPES-1:0] mask_q, mask_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [REP_W-1:0]   per_q, per_d;
  logic [PHASE_W-1:0] cout_q, cout_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               res_q, res_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               div_tick;
  logic               wrap;
  logic               per_last;
  logic               last_tick;
  logic [REP_W-1:0]   reps_eff;
  logic [SEL_W:0]     first_set;
  logic [SEL_W:0]     next_set;

  // {found, index} of the lowest set bit at or above lo
  function automatic logic [SEL_W:0] find_set(
    input logic [NSHAPES-1:0] m,
    input logic [SEL_W:0]     lo
  );
    find_set = '0;
    for (int i = NSHAPES - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(lo))) begin
        find_set = {1'b1, SEL_W'(i)};
      end
    end
  endfunction

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load_i    (state_q == S_LOAD),
    .en_i      ((state_q == S_RUN) && !stop),
    .div_val_i (fdiv_q),
    .tick_o    (div_tick)
  );

  assign reps_eff  = (reps_q == '0) ? REP_W'(1) : reps_q;
  assign per_last  = (per_q + 1'b1) == reps_eff;
  assign wrap      = div_tick && (cout_q == '1);
  assign first_set = find_set(shape_mask, '0);
  assign next_set  = find_set(mask_q, {1'b0, sel_q} + 1'b1);
  assign last_tick = wrap && res_q && per_last && !next_set[SEL_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fdiv_q  <= '0;
      mask_q  <= '0;
      reps_q  <= '0;
      per_q   <= '0;
      cout_q  <= '0;
      sel_q   <= '0;
      res_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fdiv_q  <= fdiv_d;
      mask_q  <= mask_d;
      reps_q  <= reps_d;
      per_q   <= per_d;
      cout_q  <= cout_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop && (shape_mask != '0)) state_d = S_LOAD;
      end
      S_LOAD: state_d = stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop)           state_d = S_IDLE;
        else if (last_tick) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fdiv_d = fdiv_q;
    mask_d = mask_q;
    reps_d = reps_q;
    per_d  = per_q;
    cout_d = cout_q;
    sel_d  = sel_q;
    res_d  = res_q;
    tick_d = 1'b0;
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          fdiv_d = freq_div;
          mask_d = shape_mask;
          reps_d = reps;
          per_d  = '0;
          if (shape_mask == '0) begin
            done_d = 1'b1;
          end else begin
            sel_d  = first_set[SEL_W-1:0];
            cout_d = '0;
            res_d  = 1'b0;
          end
        end
      end
      S_LOAD: begin
        cout_d = '0;
        res_d  = 1'b0;
        per_d  = '0;
        if (stop) sel_d = '0;
      end
      S_RUN: begin
        if (stop) begin
          cout_d = '0;
          res_d  = 1'b0;
          sel_d  = '0;
        end else if (div_tick) begin
          tick_d = 1'b1;
          cout_d = cout_q + 1'b1;
          if (wrap) begin
            res_d = ~res_q;
            // second-half wrap closes a period; maybe move to next shape
            if (res_q) begin
              if (per_last) begin
                per_d = '0;
                if (next_set[SEL_W]) sel_d = next_set[SEL_W-1:0];
              end else begin
                per_d = per_q + 1'b1;
              end
            end
          end
        end
      end
      S_DONE: begin
      end
    endcase
  end

  assign cout     = cout_q;
  assign res      = res_q;
  assign wave_sel = sel_q;
  assign tick     = tick_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer: arithmetic model of elapsed ticks
// checked every cycle, plus hand-computed literal expectations.
module tb_wave_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] freq_div;
  logic [3:0] shape_mask;
  logic [3:0] reps;
  logic [7:0] cout;
  logic       res;
  logic [1:0] wave_sel;
  logic       tick, busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wave_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .freq_div   (freq_div),
    .shape_mask (shape_mask),
    .reps       (reps),
    .cout       (cout),
    .res        (res),
    .wave_sel   (wave_sel),
    .tick       (tick),
    .busy       (busy),
    .done       (done)
  );

  // model: k = edges since the start edge; dk = edge that enters DONE
  int m_mode = 0;
  int k = 0, dk = 0, fd = 0, re = 1, nsh = 0;
  int shp[4];
  int e_cout = 0, e_res = 0, e_sel = 0;
  int e_tick = 0, e_busy = 0, e_done = 0;

  function automatic void m_eval();
    int t, per, w;
    if (k == 1) begin
      e_busy = 1; e_done = 0; e_tick = 0;
      e_cout = 0; e_res = 0; e_sel = shp[0];
    end else if (k == dk) begin
      e_busy = 0; e_done = 1; e_tick = 1;
      e_cout = 0; e_res = 0; e_sel = shp[nsh-1];
    end else begin
      t      = (k - 2) / (fd + 1);
      per    = re * 512;
      e_tick = ((k > 2) && ((k - 2) % (fd + 1) == 0)) ? 1 : 0;
      e_sel  = shp[t / per];
      w      = t % per;
      e_cout = w % 256;
      e_res  = (w / 256) % 2;
      e_busy = 1; e_done = 0;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      e_cout = 0; e_res = 0; e_sel = 0;
      e_tick = 0; e_busy = 0; e_done = 0;
    end else if (m_mode == 1) begin
      if (k == dk) begin
        m_mode = 0; e_done = 0; e_tick = 0; e_busy = 0;
      end else if (stop) begin
        m_mode = 0;
        e_cout = 0; e_res = 0; e_sel = 0;
        e_tick = 0; e_busy = 0; e_done = 0;
      end else begin
        k++;
        m_eval();
      end
    end else begin
      e_done = 0; e_tick = 0;
      if (start && !stop) begin
        fd  = int'(freq_div);
        re  = (reps == 0) ? 1 : int'(reps);
        nsh = 0;
        for (int i = 0; i < 4; i++)
          if (shape_mask[i]) begin shp[nsh] = i; nsh++; end
        if (nsh == 0) begin
          e_done = 1;
        end else begin
          m_mode = 1; k = 1;
          dk = 2 + nsh * re * 512 * (fd + 1);
          m_eval();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({cout, res, wave_sel, tick, busy, done} !==
          {8'(e_cout), 1'(e_res), 2'(e_sel), 1'(e_tick), 1'(e_busy), 1'(e_done)}) begin
        n_fail++;
        $display("FAIL model t=%0t got cout=%0d res=%0d sel=%0d tick=%0d busy=%0d done=%0d exp cout=%0d res=%0d sel=%0d tick=%0d busy=%0d done=%0d",
                 $time, cout, res, wave_sel, tick, busy, done,
                 e_cout, e_res, e_sel, e_tick, e_busy, e_done);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  int r_cyc, r_tk, r_res256, r_sel3, r_busy1;

  // call with start already raised; runs until done or budget
  task automatic run_done(input int max, input int glitch);
    r_cyc = 0; r_tk = 0; r_res256 = -1; r_sel3 = 0; r_busy1 = 0;
    forever begin
      @(negedge clk);
      r_cyc++;
      if (r_cyc == 1) begin start = 1'b0; r_busy1 = int'(busy); end
      if (glitch > 1 && r_cyc == glitch) start = 1'b1;
      if (glitch > 1 && r_cyc == glitch + 1) start = 1'b0;
      if (tick) begin
        r_tk++;
        if (r_tk == 256) r_res256 = int'(res);
      end
      if (busy && wave_sel == 2'd3) r_sel3++;
      if (done) break;
      if (r_cyc >= max) begin
        n_chk++; n_fail++;
        $display("FAIL run_timeout got=%0d cycles exp=done", r_cyc);
        break;
      end
    end
  endtask

  task automatic wait_out(input int cv, input int rv, input int max);
    int c = 0;
    while (!(cout == 8'(cv) && (rv < 0 || res == 1'(rv)))) begin
      @(negedge clk);
      c++;
      if (c >= max) begin
        n_chk++; n_fail++;
        $display("FAIL wait_timeout got cout=%0d exp=%0d", cout, cv);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    freq_div = '0; shape_mask = '0; reps = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset", int'({cout, res, wave_sel, tick, busy, done}), 0);
    rst = 1'b0;
    @(negedge clk);

    freq_div = 8'd0; shape_mask = 4'b0001; reps = 4'd1; start = 1'b1;
    run_done(2000, 0);
    check("t2_busy", r_busy1, 1);
    check("t2_cycles", r_cyc, 514);
    check("t2_ticks", r_tk, 512);
    check("t2_res256", r_res256, 1);
    @(negedge clk);
    check("t2_done_once", int'({done, busy}), 0);

    freq_div = 8'd3; shape_mask = 4'b1010; reps = 4'd2; start = 1'b1;
    run_done(10000, 0);
    check("t3_cycles", r_cyc, 8194);
    check("t3_ticks", r_tk, 2048);
    check("t3_sel3", r_sel3, 4096);
    @(negedge clk);

    shape_mask = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_done", int'(done), 1);
    check("t4_busy", int'(busy), 0);
    check("t4_cout", int'(cout), 0);
    @(negedge clk);
    check("t4_pulse", int'({done, busy}), 0);

    freq_div = 8'd0; shape_mask = 4'b0110; reps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_out(100, -1, 500);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t5_stop", int'({cout, res, wave_sel, tick, busy, done}), 0);
    @(negedge clk);
    check("t5_nodone", int'(done), 0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("t5_startstop", int'({busy, done}), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_sel", int'(wave_sel), 1);
    check("t5_cout", int'(cout), 0);
    repeat (10) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    freq_div = 8'd0; shape_mask = 4'b0001; reps = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_out(37, 1, 2000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst", int'({cout, res, wave_sel, tick, busy, done}), 0);
    @(negedge clk);

    freq_div = 8'd1; shape_mask = 4'b0100; reps = 4'd0; start = 1'b1;
    run_done(3000, 20);
    check("t6_cycles", r_cyc, 1026);
    check("t6_ticks", r_tk, 512);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
